// File: rtl/thiele_ext_arbiter.sv
// -----------------------------------------------------------------------------
// thiele_ext_arbiter
//
// Arbitrates NCH request/acknowledge channels from the Thiele CPU onto one
// shared external engine. Channels are served round-robin, one transaction at
// a time. If the engine does not answer within TIMEOUT cycles, the transaction
// completes with an error. The block also keeps transaction and timeout
// counters for the CPU status path.
//
// Ports
//   clk, rst_n    : system clock (rising edge), async active-low reset
//   ch_req[NCH]   : per-channel request level, held until that channel's ack
//   ch_addr       : per-channel address, channel k at [k*AW +: AW]
//   ch_ack[NCH]   : one-cycle completion pulse, one-hot
//   ch_err[NCH]   : qualifies ch_ack, 1 = transaction timed out
//   ch_data       : response data, valid while ch_ack is non-zero
//   ext_req       : request level to the engine
//   ext_addr      : address latched from the granted channel
//   ext_id        : index of the granted channel
//   ext_ack       : engine completion pulse (ignored outside WAIT)
//   ext_data      : engine data, sampled together with ext_ack
//   busy          : FSM is outside IDLE
//   txn_cnt       : completed transactions (ok + timeout), wraps
//   timeout_cnt   : timed-out transactions, wraps
// -----------------------------------------------------------------------------
module thiele_ext_arbiter #(
   parameter int              NCH      = 2,
   parameter int              AW       = 32,
   parameter int              DW       = 32,
   parameter int              TIMEOUT  = 1024,
   parameter logic [DW-1:0]   ERR_DATA = 32'hDEAD_0000,
   localparam int             IDW      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NCH-1:0]      ch_req,
   input  logic [NCH*AW-1:0]   ch_addr,
   output logic [NCH-1:0]      ch_ack,
   output logic [NCH-1:0]      ch_err,
   output logic [DW-1:0]       ch_data,
   output logic                ext_req,
   output logic [AW-1:0]       ext_addr,
   output logic [IDW-1:0]      ext_id,
   input  logic                ext_ack,
   input  logic [DW-1:0]       ext_data,
   output logic                busy,
   output logic [31:0]         txn_cnt,
   output logic [31:0]         timeout_cnt
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2,
      COOL = 2'd3
   } state_t;

   // Response captured on leaving WAIT
   typedef struct packed {
      logic [NCH-1:0] err;
      logic [DW-1:0]  data;
   } resp_t;

   state_t         state_q, state_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic [IDW-1:0] last_q, last_d;
   logic [IDW-1:0] id_d;
   logic [AW-1:0]  addr_d;
   logic           req_d;
   logic [NCH-1:0] ack_d;
   resp_t          resp_q, resp_d;
   logic [31:0]    txn_d, to_d;
   logic           busy_d;

   logic [IDW-1:0] rr_pick;
   logic [NCH-1:0] grant_oh;

   // Round-robin pick: first requester strictly above last_q, wrapping
   always_comb begin
      logic found;
      int   idx;
      rr_pick = last_q;
      found   = 1'b0;
      idx     = 0;
      for (int i = 1; i <= NCH; i++) begin
         idx = (int'(last_q) + i) % NCH;
         if (!found && ch_req[idx]) begin
            rr_pick = IDW'(idx);
            found   = 1'b1;
         end
      end
   end

   always_comb begin
      grant_oh         = '0;
      grant_oh[ext_id] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      last_d  = last_q;
      id_d    = ext_id;
      addr_d  = ext_addr;
      req_d   = ext_req;
      ack_d   = '0;
      resp_d  = resp_q;
      txn_d   = txn_cnt;
      to_d    = timeout_cnt;
      case (state_q)
         IDLE: begin
            if (|ch_req) begin
               id_d    = rr_pick;
               addr_d  = ch_addr[int'(rr_pick)*AW +: AW];
               req_d   = 1'b1;
               timer_d = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            timer_d = timer_q + 1'b1;
            // ext_ack has priority over a simultaneous timer expiry
            if (ext_ack) begin
               resp_d.data = ext_data;
               resp_d.err  = '0;
               ack_d       = grant_oh;
               req_d       = 1'b0;
               state_d     = RESP;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               resp_d.data = ERR_DATA;
               resp_d.err  = grant_oh;
               ack_d       = grant_oh;
               req_d       = 1'b0;
               state_d     = RESP;
            end
         end
         RESP: begin
            txn_d   = txn_cnt + 32'd1;
            if (|resp_q.err) to_d = timeout_cnt + 32'd1;
            last_d  = ext_id;
            state_d = COOL;
         end
         // Requests are not sampled here, so the requester just served can
         // drop ch_req before it would be granted again.
         COOL: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         last_q      <= IDW'(NCH - 1);
         ext_id      <= '0;
         ext_addr    <= '0;
         ext_req     <= 1'b0;
         ch_ack      <= '0;
         resp_q      <= '0;
         txn_cnt     <= '0;
         timeout_cnt <= '0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         last_q      <= last_d;
         ext_id      <= id_d;
         ext_addr    <= addr_d;
         ext_req     <= req_d;
         ch_ack      <= ack_d;
         resp_q      <= resp_d;
         txn_cnt     <= txn_d;
         timeout_cnt <= to_d;
         busy        <= busy_d;
      end
   end

   // ch_err is gated by ch_ack so it only reads as set during the pulse
   assign ch_err  = resp_q.err & ch_ack;
   assign ch_data = resp_q.data;

endmodule

// File: tb/tb_thiele_ext_arbiter.sv
module tb_thiele_ext_arbiter;

   localparam int NCH = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TO  = 16;

   logic              clk;
   logic              rst_n;
   logic [NCH-1:0]    ch_req;
   logic [NCH*AW-1:0] ch_addr;
   logic [NCH-1:0]    ch_ack;
   logic [NCH-1:0]    ch_err;
   logic [DW-1:0]     ch_data;
   logic              ext_req;
   logic [AW-1:0]     ext_addr;
   logic [0:0]        ext_id;
   logic              ext_ack;
   logic [DW-1:0]     ext_data;
   logic              busy;
   logic [31:0]       txn_cnt;
   logic [31:0]       timeout_cnt;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int cyc      = 0;

   thiele_ext_arbiter #(
      .NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(TO), .ERR_DATA(32'hDEAD_0000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_addr(ch_addr),
      .ch_ack(ch_ack), .ch_err(ch_err), .ch_data(ch_data),
      .ext_req(ext_req), .ext_addr(ext_addr), .ext_id(ext_id),
      .ext_ack(ext_ack), .ext_data(ext_data), .busy(busy),
      .txn_cnt(txn_cnt), .timeout_cnt(timeout_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      ch_req  = '0;
      ext_ack = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      ch_req   = '0;
      ch_addr  = '0;
      ext_ack  = 1'b0;
      ext_data = '0;
      tick();
      chk_cnt++;
      if ({ext_req, ext_addr, ext_id} !== '0)
         $display("FAIL reset_ext: got req=%b addr=%h id=%0d want 0", ext_req, ext_addr, ext_id);
      else pass_cnt++;
      chk_cnt++;
      if ({ch_ack, ch_err, ch_data} !== '0)
         $display("FAIL reset_ch: got ack=%b err=%b data=%h want 0", ch_ack, ch_err, ch_data);
      else pass_cnt++;
      chk_cnt++;
      if ({busy, txn_cnt, timeout_cnt} !== '0)
         $display("FAIL reset_cnt: got busy=%b txn=%0d to=%0d want 0", busy, txn_cnt, timeout_cnt);
      else pass_cnt++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      ch_addr[0*AW +: AW] = 32'h40;
      ch_addr[1*AW +: AW] = 32'h99;
      ch_req = 2'b01;
      tick();
      chk_cnt++;
      if ({ext_req, busy, ext_id, ext_addr} !== {1'b1, 1'b1, 1'b0, 32'h40})
         $display("FAIL single_issue: got req=%b busy=%b id=%0d addr=%h want 1 1 0 40",
                  ext_req, busy, ext_id, ext_addr);
      else pass_cnt++;
      tick();
      tick();
      ext_ack  = 1'b1;
      ext_data = 32'hABCD_1234;
      tick();
      ext_ack  = 1'b0;
      ch_req   = 2'b00;
      chk_cnt++;
      if ({ch_ack, ch_err, ext_req} !== {2'b01, 2'b00, 1'b0})
         $display("FAIL single_ack: got ack=%b err=%b ext_req=%b want 01 00 0", ch_ack, ch_err, ext_req);
      else pass_cnt++;
      chk_cnt++;
      if (ch_data !== 32'hABCD_1234)
         $display("FAIL single_data: got %h want abcd1234", ch_data);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({ch_ack, txn_cnt, timeout_cnt} !== {2'b00, 32'd1, 32'd0})
         $display("FAIL single_after: got ack=%b txn=%0d to=%0d want 00 1 0", ch_ack, txn_cnt, timeout_cnt);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (busy !== 1'b0)
         $display("FAIL single_idle: got busy=%b want 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_round_robin();
      int       last_cyc;
      logic [0:0] exp_id;
      bit       seen;
      do_reset();
      ch_req   = 2'b11;
      last_cyc = -1;
      for (int k = 0; k < 4; k++) begin
         exp_id = 1'(k % 2);
         seen   = 1'b0;
         for (int w = 0; w < 10 && !seen; w++) begin
            tick();
            if (ext_req) seen = 1'b1;
         end
         chk_cnt++;
         if (!seen) begin
            $display("FAIL rr_issue%0d: ext_req never rose within 10 cycles, want issue", k);
         end else if (ext_id !== exp_id) begin
            $display("FAIL rr_order%0d: got id=%0d want %0d", k, ext_id, exp_id);
         end else pass_cnt++;
         if (k > 0) begin
            chk_cnt++;
            if (cyc - last_cyc !== 4)
               $display("FAIL rr_spacing%0d: got %0d cycles want 4", k, cyc - last_cyc);
            else pass_cnt++;
         end
         last_cyc = cyc;
         ext_ack  = 1'b1;
         ext_data = 32'h100 + 32'(k);
         tick();
         ext_ack = 1'b0;
         if (k == 3) ch_req = 2'b00;
         chk_cnt++;
         if ({ch_ack, ch_data} !== {2'b01 << exp_id, 32'h100 + 32'(k)})
            $display("FAIL rr_ack%0d: got ack=%b data=%h want %b %h",
                     k, ch_ack, ch_data, 2'b01 << exp_id, 32'h100 + 32'(k));
         else pass_cnt++;
      end
      tick();
      tick();
      chk_cnt++;
      if ({busy, txn_cnt} !== {1'b0, 32'd4})
         $display("FAIL rr_end: got busy=%b txn=%0d want 0 4", busy, txn_cnt);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      int  hi_cnt;
      bit  done;
      do_reset();
      ch_addr[1*AW +: AW] = 32'h80;
      ch_req = 2'b10;
      hi_cnt = 0;
      done   = 1'b0;
      for (int w = 0; w < 40 && !done; w++) begin
         tick();
         if (ext_req) hi_cnt++;
         if (ch_ack != '0) done = 1'b1;
      end
      ch_req = 2'b00;
      chk_cnt++;
      if (!done)
         $display("FAIL to_ack: no ch_ack within 40 cycles, want one");
      else if ({ch_ack, ch_err, ch_data} !== {2'b10, 2'b10, 32'hDEAD_0000})
         $display("FAIL to_ack: got ack=%b err=%b data=%h want 10 10 dead0000", ch_ack, ch_err, ch_data);
      else pass_cnt++;
      chk_cnt++;
      if (hi_cnt !== TO)
         $display("FAIL to_len: ext_req high %0d cycles want %0d", hi_cnt, TO);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({ch_ack, timeout_cnt, txn_cnt} !== {2'b00, 32'd1, 32'd1})
         $display("FAIL to_cnt: got ack=%b to=%0d txn=%0d want 00 1 1", ch_ack, timeout_cnt, txn_cnt);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_ack_at_expiry();
      do_reset();
      ch_req = 2'b01;
      tick();
      for (int i = 0; i < TO - 1; i++) tick();
      chk_cnt++;
      if ({ext_req, ch_ack} !== {1'b1, 2'b00})
         $display("FAIL exp_pre: got req=%b ack=%b want 1 00", ext_req, ch_ack);
      else pass_cnt++;
      ext_ack  = 1'b1;
      ext_data = 32'h1234_5678;
      tick();
      ext_ack = 1'b0;
      ch_req  = 2'b00;
      chk_cnt++;
      if ({ch_ack, ch_err, ch_data} !== {2'b01, 2'b00, 32'h1234_5678})
         $display("FAIL exp_ack: got ack=%b err=%b data=%h want 01 00 12345678", ch_ack, ch_err, ch_data);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({timeout_cnt, txn_cnt} !== {32'd0, 32'd1})
         $display("FAIL exp_cnt: got to=%0d txn=%0d want 0 1", timeout_cnt, txn_cnt);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_stray_and_drop();
      int acks;
      do_reset();
      ext_ack  = 1'b1;
      ext_data = 32'hBAD0_BAD0;
      tick();
      ext_ack = 1'b0;
      tick();
      chk_cnt++;
      if ({busy, ext_req, ch_ack, txn_cnt} !== {1'b0, 1'b0, 2'b00, 32'd0})
         $display("FAIL stray: got busy=%b req=%b ack=%b txn=%0d want 0 0 00 0",
                  busy, ext_req, ch_ack, txn_cnt);
      else pass_cnt++;
      ch_req = 2'b01;
      tick();
      tick();
      ch_req = 2'b00;
      acks   = 0;
      tick();
      tick();
      ext_ack  = 1'b1;
      ext_data = 32'h0000_55AA;
      tick();
      ext_ack = 1'b0;
      chk_cnt++;
      if ({ch_ack, ch_data} !== {2'b01, 32'h0000_55AA})
         $display("FAIL drop_ack: got ack=%b data=%h want 01 000055aa", ch_ack, ch_data);
      else pass_cnt++;
      if (ch_ack != '0) acks++;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (ch_ack != '0) acks++;
      end
      chk_cnt++;
      if ({acks, txn_cnt, busy} !== {32'd1, 32'd1, 1'b0})
         $display("FAIL drop_once: got pulses=%0d txn=%0d busy=%b want 1 1 0", acks, txn_cnt, busy);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_wait();
      int acks;
      do_reset();
      ch_req = 2'b10;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({ext_req, busy, ch_ack, txn_cnt, timeout_cnt} !== '0)
         $display("FAIL rst_async: got req=%b busy=%b ack=%b txn=%0d to=%0d want all 0",
                  ext_req, busy, ch_ack, txn_cnt, timeout_cnt);
      else pass_cnt++;
      rst_n  = 1'b1;
      ch_req = 2'b11;
      acks   = 0;
      tick();
      if (ch_ack != '0) acks++;
      chk_cnt++;
      if ({ext_req, ext_id, ext_addr} !== {1'b1, 1'b0, 32'h40})
         $display("FAIL rst_regrant: got req=%b id=%0d addr=%h want 1 0 40", ext_req, ext_id, ext_addr);
      else pass_cnt++;
      ext_ack  = 1'b1;
      ext_data = 32'hC0DE_0001;
      tick();
      ext_ack = 1'b0;
      ch_req  = 2'b00;
      if (ch_ack != '0) acks++;
      chk_cnt++;
      if ({ch_ack, ch_err, ch_data} !== {2'b01, 2'b00, 32'hC0DE_0001})
         $display("FAIL rst_serve: got ack=%b err=%b data=%h want 01 00 c0de0001", ch_ack, ch_err, ch_data);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({acks, txn_cnt, timeout_cnt} !== {32'd1, 32'd1, 32'd0})
         $display("FAIL rst_cnt: got pulses=%0d txn=%0d to=%0d want 1 1 0", acks, txn_cnt, timeout_cnt);
      else pass_cnt++;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_ack_at_expiry();
      test_stray_and_drop();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

endmodule
